fork_join_scheduler: RTL and testbench
======================================

Name: fork_join_scheduler

Overview:
- Hardware analogue of fork/join process control for the process-synchronisation test bench.
- Launches up to N_TASKS parallel countdown "tasks", each with its own programmable delay.
- Tracks each task to completion and signals the join point in three modes: join (all tasks), join_any (first task) or join_none (immediate).
- Also signals the wait-fork point, where every launched task has finished.

Parameters:
- N_TASKS, 4, number of parallel task slots.
- DLY_W, 8, width of each per-task delay field.
- ID_W, 2, width of a task index; must equal clog2(N_TASKS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; accepted only when ready=1.
- mode  in  2  join mode, sampled at accept: 00 join, 01 join_any, 10 join_none, 11 treated as join.
- task_en  in  N_TASKS  per-slot launch mask, sampled at accept.
- task_dly  in  N_TASKS*DLY_W  per-slot delay; slot i uses bits [i*DLY_W +: DLY_W]; sampled at accept.
- abort  in  1  kill all active tasks (disable fork).
- ready  out  1  high in IDLE; start accepted only then.
- busy  out  1  high whenever any task is active.
- active  out  N_TASKS  per-slot running mask.
- task_done  out  N_TASKS  one-cycle pulse per slot when it completes.
- join_done  out  1  one-cycle pulse at the join point for the sampled mode.
- first_id  out  ID_W  index of the first-completing slot; lowest index wins a tie; held until next accept.
- all_done  out  1  one-cycle pulse when the last active task completes (wait fork).
- aborted  out  1  one-cycle pulse when an abort takes effect.

Behaviour:
- Reset values: all outputs 0 except ready=1; state IDLE; all counters 0.
- States:
  - IDLE: go to RUN on start&&ready.
  - RUN: go to IDLE on the all_done cycle or on abort.
- Accept cycle T: start=1 while in IDLE.
  - Latch mode and task_en.
  - Load counter[i]=task_dly[i] for each enabled slot.
  - active <= task_en.
  - ready drops from T+1 onward.
- Countdown: in RUN, each active slot with counter>0 decrements once per cycle.
  - A slot with counter==0 pulses task_done[i] in that cycle and clears its active bit at the next edge.
  - Result: slot i with delay d pulses task_done in cycle T+1+d. Delay 0 pulses at T+1; delay 2^DLY_W-1 pulses at T+2^DLY_W.
- Simultaneous completions: multiple task_done bits may pulse in the same cycle.
- all_done: pulses in the cycle of the last task_done, in every mode. The state returns to IDLE, and ready=1 in the following cycle.
- join_done timing by mode:
  - join: same cycle as all_done.
  - join_any: same cycle as the first task_done pulse(s).
  - join_none: cycle T+1, regardless of completions.
  - join_done pulses exactly once per launch.
- first_id: updated in the cycle of the first completion to the lowest-index slot pulsing then. It is updated in every mode, not only join_any.
- task_en==0 at accept: join_done and all_done both pulse at T+1, no task_done pulses, return to IDLE; first_id keeps its previous value.
- busy = |active. active and busy stay high through each slot's task_done cycle.
- Abort in RUN, cycle A:
  - aborted=1.
  - No task_done, join_done or all_done in cycle A, even if slots reach 0 that cycle (abort wins).
  - active cleared and state IDLE at the next edge; ready=1 at A+1.
  - If join_done already pulsed earlier, it is not repeated.
- Abort in IDLE: ignored, aborted stays 0. start and abort in the same IDLE cycle: start accepted, abort ignored.
- start while not ready: ignored, no state change.
- rst mid-run: all slots are killed immediately and outputs go to reset values, with no pulses emitted.

Test Plan:
- Mode join, en=0111, dly={slot0:30, slot1:7, slot2:10}, accept at T:
  - task_done[1]@T+8, [2]@T+11, [0]@T+31.
  - join_done and all_done @T+31.
  - first_id=1; ready=1@T+32.
- Mode join_none, same delays:
  - join_done @T+1.
  - task_done pulses as in the join case; all_done @T+31.
  - busy high T+1..T+31.
  - start at T+5 ignored.
- Mode join_any, en=1111, dly={5,1,1,9}:
  - task_done[1] and [2] together @T+2.
  - join_done @T+2, first_id=1.
  - task_done[0]@T+6; task_done[3] and all_done @T+10.
- Mode join, en=0011, dly={0,0}:
  - task_done=0011, join_done and all_done all @T+1.
  - en=0000: join_done and all_done @T+1, no task_done.
- Abort:
  - Mode join, dly slot0=20, abort at T+6: aborted@T+6, no other pulses, ready@T+7.
  - Abort at T+21 (slot0's completion cycle): aborted only, no task_done[0].
- Reset:
  - rst at T+3 of a running join: next cycle active=0, ready=1, no pulses.
  - New start then completes normally.

Source files
------------

// File: rtl/fork_join_scheduler.sv
// rtl/fork_join_scheduler.sv - fork/join process control: parallel countdown tasks with join, join_any, join_none and wait-fork signalling
module fork_join_scheduler #(
    parameter int N_TASKS = 4,
    parameter int DLY_W   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [N_TASKS-1:0]       task_en,
    input  logic [N_TASKS*DLY_W-1:0] task_dly,
    input  logic                     abort,
    output logic                     ready,
    output logic                     busy,
    output logic [N_TASKS-1:0]       active,
    output logic [N_TASKS-1:0]       task_done,
    output logic                     join_done,
    output logic [ID_W-1:0]          first_id,
    output logic                     all_done,
    output logic                     aborted
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [1:0] MODE_ANY  = 2'b01;
    localparam logic [1:0] MODE_NONE = 2'b10;

    state_t               state;
    state_t               state_nxt;
    logic [DLY_W-1:0]     counter [N_TASKS];
    logic [N_TASKS-1:0]   active_q;
    logic [N_TASKS-1:0]   zero_mask;
    logic [N_TASKS-1:0]   done_now;
    logic [1:0]           mode_q;
    logic                 join_fired;
    logic                 first_seen;
    logic [ID_W-1:0]      first_id_q;
    logic [ID_W-1:0]      first_idx;
    logic                 accept;
    logic                 live;
    logic                 finishing;
    logic                 join_cond;
    logic                 first_event;

    assign accept = (state == S_IDLE) && start;
    // Abort and reset both suppress every completion-related pulse in their cycle.
    assign live   = (state == S_RUN) && !abort && !rst;

    always_comb begin
        zero_mask = '0;
        for (int i = 0; i < N_TASKS; i++) begin
            zero_mask[i] = (counter[i] == '0);
        end
    end

    assign done_now    = active_q & zero_mask & {N_TASKS{live}};
    // With no slot left running after this cycle the fork is complete; covers an empty launch too.
    assign finishing   = live && ((active_q & ~done_now) == '0);
    assign first_event = (|done_now) && !first_seen;

    always_comb begin
        first_idx = '0;
        for (int i = N_TASKS - 1; i >= 0; i--) begin
            if (done_now[i]) begin
                first_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        join_cond = finishing;
        case (mode_q)
            MODE_ANY:  join_cond = (|done_now) || finishing;
            MODE_NONE: join_cond = live;
            default:   join_cond = finishing;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN:  if (abort || finishing) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == S_IDLE);
        task_done = done_now;
        all_done  = finishing;
        join_done = !join_fired && join_cond;
        aborted   = (state == S_RUN) && abort && !rst;
        first_id  = first_event ? first_idx : first_id_q;
    end

    assign active = active_q;
    assign busy   = |active_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= '0;
            mode_q     <= '0;
            join_fired <= 1'b0;
            first_seen <= 1'b0;
            first_id_q <= '0;
            for (int i = 0; i < N_TASKS; i++) begin
                counter[i] <= '0;
            end
        end else if (accept) begin
            active_q   <= task_en;
            mode_q     <= mode;
            join_fired <= 1'b0;
            first_seen <= 1'b0;
            for (int i = 0; i < N_TASKS; i++) begin
                counter[i] <= task_en[i] ? task_dly[i*DLY_W +: DLY_W] : '0;
            end
        end else if (state == S_RUN) begin
            if (abort) begin
                active_q <= '0;
                for (int i = 0; i < N_TASKS; i++) begin
                    counter[i] <= '0;
                end
            end else begin
                active_q <= active_q & ~done_now;
                for (int i = 0; i < N_TASKS; i++) begin
                    if (active_q[i] && !zero_mask[i]) begin
                        counter[i] <= counter[i] - 1'b1;
                    end
                end
                if (join_done) begin
                    join_fired <= 1'b1;
                end
                if (first_event) begin
                    first_seen <= 1'b1;
                    first_id_q <= first_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_fork_join_scheduler.sv
// tb/tb_fork_join_scheduler.sv - self-checking bench for fork_join_scheduler
module tb_fork_join_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  task_en;
    logic [31:0] task_dly;
    logic        abort;
    logic        ready;
    logic        busy;
    logic [3:0]  active;
    logic [3:0]  task_done;
    logic        join_done;
    logic [1:0]  first_id;
    logic        all_done;
    logic        aborted;

    fork_join_scheduler #(.N_TASKS(4), .DLY_W(8), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .task_en(task_en),
        .task_dly(task_dly), .abort(abort), .ready(ready), .busy(busy),
        .active(active), .task_done(task_done), .join_done(join_done),
        .first_id(first_id), .all_done(all_done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each launched slot finishes at offset 1+delay from its accept cycle.
    logic       m_run;
    int         m_k;
    logic [1:0] m_mode;
    logic [3:0] m_en;
    int         m_d [4];
    logic       m_fired;
    logic       m_seen;
    logic [1:0] m_first;

    logic       s_ready, s_join, s_all, s_aborted;
    logic [3:0] s_active;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  en;
        logic [31:0] dly;
        int          abort_k;
        int          exp_join_k;
        int          exp_all_k;
        int          exp_abort_k;
        int          exp_ready_k;
        logic [1:0]  exp_first;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_k = 0; m_mode = '0; m_en = '0;
        m_fired = 1'b0; m_seen = 1'b0; m_first = '0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    task automatic step(input logic s, input logic [1:0] md, input logic [3:0] en,
                        input logic [31:0] dl, input logic ab, input logic r);
        logic       e_ready, e_busy, e_join, e_all, e_ab, live;
        logic [3:0] e_active, e_done;
        logic [1:0] e_first;
        int         lastk;
        start = s; mode = md; task_en = en; task_dly = dl; abort = ab; rst = r;
        #1;
        live     = m_run && !ab && !r;
        e_ready  = !m_run;
        e_active = '0;
        e_done   = '0;
        lastk    = 1;
        for (int i = 0; i < 4; i++) begin
            if (m_run && m_en[i] && (m_d[i] + 1 >= m_k)) e_active[i] = 1'b1;
            if (live && m_en[i] && (m_d[i] + 1 == m_k)) e_done[i] = 1'b1;
            if (m_en[i] && (m_d[i] + 1 > lastk)) lastk = m_d[i] + 1;
        end
        e_busy = |e_active;
        e_all  = live && (lastk == m_k);
        if (m_mode == 2'b01)      e_join = live && !m_fired && ((|e_done) || e_all);
        else if (m_mode == 2'b10) e_join = live && !m_fired;
        else                      e_join = live && !m_fired && e_all;
        e_first = m_first;
        if ((|e_done) && !m_seen) begin
            for (int i = 3; i >= 0; i--) if (e_done[i]) e_first = 2'(i);
        end
        e_ab = m_run && ab && !r;

        chk("ready", 32'(ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("active", 32'(active), 32'(e_active));
        chk("task_done", 32'(task_done), 32'(e_done));
        chk("join_done", 32'(join_done), 32'(e_join));
        chk("all_done", 32'(all_done), 32'(e_all));
        chk("aborted", 32'(aborted), 32'(e_ab));
        chk("first_id", 32'(first_id), 32'(e_first));
        s_ready = ready; s_join = join_done; s_all = all_done;
        s_aborted = aborted; s_active = active;

        if (r) begin
            model_reset();
        end else if (m_run) begin
            if (e_join) m_fired = 1'b1;
            if ((|e_done) && !m_seen) begin
                m_seen = 1'b1;
                m_first = e_first;
            end
            if (ab || e_all) m_run = 1'b0;
            else m_k++;
        end else if (s) begin
            m_run = 1'b1; m_k = 1; m_mode = md; m_en = en;
            m_fired = 1'b0; m_seen = 1'b0;
            for (int i = 0; i < 4; i++) m_d[i] = int'(dl[i*8 +: 8]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx);
        int got_join, got_all, got_ab, got_ready;
        vec_t v;
        v = vecs[idx];
        got_join = 0; got_all = 0; got_ab = 0; got_ready = 0;
        step(1'b1, v.mode, v.en, v.dly, 1'b0, 1'b0);
        for (int k = 1; k <= 400; k++) begin
            step(k == 5, v.mode, v.en, v.dly, k == v.abort_k, 1'b0);
            if (s_join && got_join == 0) got_join = k;
            if (s_all && got_all == 0) got_all = k;
            if (s_aborted && got_ab == 0) got_ab = k;
            if (s_ready) begin
                got_ready = k;
                break;
            end
        end
        chk($sformatf("vec%0d join_k", idx), 32'(got_join), 32'(v.exp_join_k));
        chk($sformatf("vec%0d all_k", idx), 32'(got_all), 32'(v.exp_all_k));
        chk($sformatf("vec%0d abort_k", idx), 32'(got_ab), 32'(v.exp_abort_k));
        chk($sformatf("vec%0d ready_k", idx), 32'(got_ready), 32'(v.exp_ready_k));
        chk($sformatf("vec%0d first_id", idx), 32'(first_id), 32'(v.exp_first));
    endtask

    initial begin
        vecs[0] = '{2'b00, 4'b0111, {8'd0, 8'd10, 8'd7, 8'd30}, 0, 31, 31, 0, 32, 2'd1};
        vecs[1] = '{2'b10, 4'b0111, {8'd0, 8'd10, 8'd7, 8'd30}, 0, 1, 31, 0, 32, 2'd1};
        vecs[2] = '{2'b01, 4'b1111, {8'd9, 8'd1, 8'd1, 8'd5}, 0, 2, 10, 0, 11, 2'd1};
        vecs[3] = '{2'b00, 4'b0000, 32'd0, 0, 1, 1, 0, 2, 2'd1};
        vecs[4] = '{2'b00, 4'b0011, 32'd0, 0, 1, 1, 0, 2, 2'd0};
        vecs[5] = '{2'b00, 4'b0001, 32'd20, 6, 0, 0, 6, 7, 2'd0};
        vecs[6] = '{2'b00, 4'b0001, 32'd20, 21, 0, 0, 21, 22, 2'd0};
        vecs[7] = '{2'b11, 4'b0101, {8'd0, 8'd6, 8'd0, 8'd3}, 0, 7, 7, 0, 8, 2'd0};
        vecs[8] = '{2'b00, 4'b1000, {8'd255, 24'd0}, 0, 256, 256, 0, 257, 2'd3};
        vecs[9] = '{2'b01, 4'b1001, {8'd2, 8'd0, 8'd0, 8'd2}, 0, 3, 3, 0, 4, 2'd0};

        start = 0; mode = 0; task_en = 0; task_dly = 0; abort = 0; rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset active", 32'(active), 32'd0);
        chk("reset pulses", 32'({task_done, join_done, all_done, aborted}), 32'd0);
        chk("reset first_id", 32'(first_id), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Reset in the middle of a run, then a normal launch.
        step(1'b1, 2'b00, 4'b0001, 32'd20, 1'b0, 1'b0);
        step(1'b0, 2'b00, 4'b0001, 32'd20, 1'b0, 1'b0);
        step(1'b0, 2'b00, 4'b0001, 32'd20, 1'b0, 1'b0);
        step(1'b0, 2'b00, 4'b0001, 32'd20, 1'b0, 1'b1);
        step(1'b0, 2'b00, 4'b0000, 32'd0, 1'b0, 1'b0);
        chk("post-rst active", 32'(s_active), 32'd0);
        chk("post-rst ready", 32'(s_ready), 32'd1);
        run_vec(0);

        // start together with abort while idle: start wins, abort ignored.
        step(1'b1, 2'b00, 4'b0010, {8'd0, 8'd0, 8'd3, 8'd0}, 1'b1, 1'b0);
        chk("idle abort ignored", 32'(s_aborted), 32'd0);
        for (int k = 0; k < 6; k++) step(1'b0, 2'b00, 4'b0000, 32'd0, 1'b0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] dl;
            for (int i = 0; i < 4; i++) begin
                int r;
                r = $urandom_range(0, 15);
                dl[i*8 +: 8] = (r == 15) ? 8'd255 : 8'(r);
            end
            step(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), dl,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
